imem_loader: RTL and testbench

//  Byte-stream program loader: writer side of the unified program/data BRAM that the cpu fetches from.

---
 rtl/imem_loader.sv | 123 ++++++++++++
 tb/tb_imem_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader that fills instruction memory and gates cpu reset
module imem_loader #(
    parameter int          ADDR_WIDTH     = 13,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic                  sysclk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t              r_state, w_next;
    logic [7:0]          r_len_lo;
    logic [15:0]         r_len;
    logic [ADDR_WIDTH:0] r_widx;
    logic [1:0]          r_bidx;
    logic [31:0]         r_word;
    logic [7:0]          r_sum;
    logic [TW-1:0]       r_tcnt;

    logic                w_hs;
    logic                w_timed;
    logic                w_timeout;
    logic [15:0]         w_len;
    logic [ADDR_WIDTH:0] w_widx_inc;

    assign w_hs       = rx_valid && rx_ready;
    assign w_timed    = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                        (r_state == S_DATA)   || (r_state == S_CHK);
    // A byte landing on the expiry cycle is taken rather than discarded.
    assign w_timeout  = w_timed && !w_hs && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign w_len      = {rx_data, r_len_lo};
    assign w_widx_inc = r_widx + 1'b1;

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR:
                if (w_hs && rx_data == SYNC_BYTE) w_next = S_LEN_LO;
            S_LEN_LO:
                if (w_hs) w_next = S_LEN_HI;
            S_LEN_HI:
                if (w_hs) begin
                    if (w_len == 16'd0)                               w_next = S_CHK;
                    else if (32'(w_len) > (32'd1 << ADDR_WIDTH))      w_next = S_ERR;
                    else                                              w_next = S_DATA;
                end
            S_DATA:
                if (w_hs && r_bidx == 2'd3) w_next = S_WRITE;
            S_WRITE:
                w_next = (32'(w_widx_inc) == 32'(r_len)) ? S_CHK : S_DATA;
            S_CHK:
                if (w_hs) w_next = (rx_data == r_sum) ? S_DONE : S_ERR;
            default:
                w_next = S_IDLE;
        endcase
        if (w_timeout) w_next = S_ERR;
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_len_lo <= '0;
            r_len    <= '0;
            r_widx   <= '0;
            r_bidx   <= '0;
            r_word   <= '0;
            r_sum    <= '0;
            r_tcnt   <= '0;
        end else begin
            r_tcnt <= (w_timed && !w_hs) ? r_tcnt + 1'b1 : '0;
            if (r_state == S_WRITE) r_widx <= w_widx_inc;
            if (w_hs) begin
                case (r_state)
                    S_LEN_LO: r_len_lo <= rx_data;
                    S_LEN_HI: begin
                        r_len  <= w_len;
                        r_widx <= '0;
                        r_bidx <= '0;
                        r_sum  <= '0;
                    end
                    S_DATA: begin
                        r_word[{r_bidx, 3'b000} +: 8] <= rx_data;
                        r_sum                          <= r_sum + rx_data;
                        r_bidx                         <= r_bidx + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Write port and status are pure decodes of state so reset silences them at once.
    assign mem_en    = (r_state == S_WRITE);
    assign mem_we    = mem_en ? 4'b1111 : 4'b0000;
    assign mem_addr  = r_widx[ADDR_WIDTH-1:0];
    assign mem_wdata = r_word;
    assign rx_ready  = (r_state != S_WRITE);
    assign busy      = w_timed || (r_state == S_WRITE);
    assign done      = (r_state == S_DONE);
    assign error     = (r_state == S_ERR);
    assign cpu_rst   = (r_state != S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader with a frame-level reference model
module tb_imem_loader;
    localparam int AW = 2;
    localparam int ST_IDLE = 0, ST_BUSY = 1, ST_DONE = 2, ST_ERR = 3;

    typedef logic [7:0] bq_t[$];

    logic          sysclk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic          cpu_rst, busy, done, error;

    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [63:0]   exp_q[$];

    imem_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(16)) dut (
        .sysclk(sysclk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_en(mem_en), .mem_we(mem_we), .cpu_rst(cpu_rst), .busy(busy),
        .done(done), .error(error)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Parses a byte list the way a frame is defined and queues the words it must write.
    task automatic model(input bq_t b, output int st);
        int i;
        int n;
        logic [7:0]  sum;
        logic [31:0] w;
        i = 0;
        sum = 8'd0;
        while (i < b.size() && b[i] != 8'hA5) i++;
        if (i >= b.size()) begin st = ST_IDLE; return; end
        i++;
        if (i + 2 > b.size()) begin st = ST_BUSY; return; end
        n = int'(b[i]) + 256 * int'(b[i+1]);
        i += 2;
        if (n > (1 << AW)) begin st = ST_ERR; return; end
        for (int k = 0; k < n; k++) begin
            if (i + 4 > b.size()) begin st = ST_BUSY; return; end
            w = {b[i+3], b[i+2], b[i+1], b[i]};
            sum = sum + b[i] + b[i+1] + b[i+2] + b[i+3];
            exp_q.push_back({32'(k), w});
            i += 4;
        end
        if (i >= b.size()) st = ST_BUSY;
        else               st = (b[i] == sum) ? ST_DONE : ST_ERR;
    endtask

    task automatic send_byte(input logic [7:0] v);
        bit hs;
        int t;
        rx_data = v;
        rx_valid = 1'b1;
        hs = 1'b0;
        t = 0;
        while (!hs && t < 50) begin
            @(negedge sysclk);
            hs = rx_ready;
            @(posedge sysclk);
            #1;
            t++;
        end
        rx_valid = 1'b0;
        if (!hs) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: byte %0h not accepted, wanted a handshake", v);
        end
    endtask

    task automatic send_all(input bq_t b);
        foreach (b[i]) send_byte(b[i]);
    endtask

    task automatic chk_status(input string nm, input bit d, input bit e);
        check({nm, "_status"}, {60'd0, done, error, cpu_rst, busy}, {60'd0, d, e, ~d, 1'b0});
    endtask

    task automatic end_frame(input string nm, input int st);
        if (st == ST_DONE)     chk_status(nm, 1'b1, 1'b0);
        else if (st == ST_ERR) chk_status(nm, 1'b0, 1'b1);
        check({nm, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Every cycle: handshake/write-enable coherence, and each write against the model queue.
    always @(negedge sysclk) begin
        logic [63:0] e;
        check("ready_vs_en", {62'd0, rx_ready, mem_we == {4{mem_en}}}, {62'd0, ~mem_en, 1'b1});
        if (mem_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {30'd0, mem_addr, mem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("write", {30'd0, mem_addr, mem_wdata}, e);
            end
        end
    end

    initial begin
        bq_t b;
        int  st;
        logic [7:0] csum;

        rst = 1'b1;
        rx_data = 8'd0;
        rx_valid = 1'b0;
        repeat (2) @(negedge sysclk);
        check("reset_outputs",
              {48'd0, rx_ready, mem_en, mem_we, 2'(mem_addr), mem_wdata == 32'd0, cpu_rst, busy, done, error, 2'd0},
              {48'd0, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0});
        @(posedge sysclk); #1;
        rst = 1'b0;

        // 1: good two-word frame
        b = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
        model(b, st);
        check("pin_t1_w0", exp_q[0], {32'd0, 32'h44332211});
        check("pin_t1_w1", exp_q[1], {32'd1, 32'h88776655});
        check("pin_t1_st", 64'(st), 64'(ST_DONE));
        send_all(b);
        end_frame("t1", st);

        // 2: bad checksum, words still land
        b = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h65};
        model(b, st);
        check("pin_t2_st", 64'(st), 64'(ST_ERR));
        send_all(b);
        end_frame("t2", st);

        // 3: leading junk, empty image
        b = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
        model(b, st);
        send_all(b);
        end_frame("t3", st);

        // 4a: oversize length
        b = '{8'hA5, 8'h05, 8'h00};
        model(b, st);
        check("pin_t4a_st", 64'(st), 64'(ST_ERR));
        send_all(b);
        end_frame("t4a", st);

        // 4b: exactly full memory
        b = '{8'hA5, 8'h04, 8'h00};
        csum = 8'd0;
        for (int i = 0; i < 16; i++) begin
            b.push_back(8'(i * 29 + 3));
            csum = csum + 8'(i * 29 + 3);
        end
        model(b, st);
        check("pin_t4b_last_addr", {32'd0, exp_q[3][63:32]}, 64'd3);
        send_all(b);
        repeat (2) @(posedge sysclk); #1;
        check("t4b_in_chk", {62'd0, busy, error}, {62'd0, 1'b1, 1'b0});
        check("t4b_writes_left", 64'(exp_q.size()), 64'd0);
        send_byte(csum);
        chk_status("t4b", 1'b1, 1'b0);

        // 5a: stall after two data bytes
        b = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD};
        model(b, st);
        send_all(b);
        repeat (15) @(posedge sysclk); #1;
        check("t5a_before_timeout", {63'd0, error}, 64'd0);
        @(posedge sysclk); #1;
        chk_status("t5a", 1'b0, 1'b1);

        // 5b: byte arrives on the expiry cycle
        b = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02};
        model(b, st);
        send_all(b);
        repeat (15) @(posedge sysclk); #1;
        send_byte(8'h03);
        check("t5b_no_timeout", {63'd0, error}, 64'd0);
        b = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        exp_q.delete();
        model(b, st);
        check("pin_t5b_st", 64'(st), 64'(ST_DONE));
        send_byte(8'h04);
        send_byte(8'h0A);
        end_frame("t5b", st);

        // 6: reset mid-word, then replay frame 1
        b = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        model(b, st);
        send_all(b);
        check("t6_pre_writes", 64'(exp_q.size()), 64'd0);
        @(negedge sysclk);
        #2 rst = 1'b1;
        #1;
        check("t6_in_reset", {60'd0, cpu_rst, mem_en, busy, rx_ready}, {60'd0, 1'b1, 1'b0, 1'b0, 1'b1});
        repeat (3) @(posedge sysclk);
        #1 rst = 1'b0;
        b = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
        model(b, st);
        send_all(b);
        end_frame("t6", st);

        repeat (3) @(posedge sysclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
